// File: rtl/click_mem_sync_bridge.sv
// Click-to-clocked bridge: catches each asynchronous drive token with its data word,
// synchronizes it into clk, stores the word in a small FIFO, then returns a free pulse upstream.
module click_mem_sync_bridge #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FREE_W      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_drive,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_free,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int FCW   = $clog2(FREE_W + 1);

    typedef enum logic [1:0] {IDLE, STORE, FREE, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic                       req_q, req_clr, req_s;
    logic                       clr_q, free_q, valid_q;
    logic [DATA_W-1:0]          hold_q;
    logic [SYNC_STAGES-1:0]     sync_pipe;
    logic [FCW-1:0]             free_cnt_q, free_cnt_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count_q, count_d;
    logic                       push, pop, full;

    // Catcher: the drive edge is the only clock here; clear comes from reset or the FREE phase.
    assign req_clr = ~rst | clr_q;

    always_ff @(posedge i_drive or posedge req_clr) begin
        if (req_clr) req_q <= 1'b0;
        else         req_q <= 1'b1;
    end

    always_ff @(posedge i_drive or negedge rst) begin
        if (!rst) hold_q <= '0;
        else      hold_q <= i_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_pipe <= '0;
        else      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], req_q};
    end

    assign req_s = sync_pipe[SYNC_STAGES-1];

    assign full = (count_q == CW'(DEPTH));
    assign pop  = valid_q & i_ready;

    always_comb begin
        state_d    = state_q;
        free_cnt_d = free_cnt_q;
        push       = 1'b0;
        case (state_q)
            IDLE:  if (req_s) state_d = STORE;
            STORE: begin
                // At full a same-cycle pop frees the slot the push lands in.
                if (!full || pop) begin
                    push       = 1'b1;
                    state_d    = FREE;
                    free_cnt_d = '0;
                end
            end
            FREE: begin
                if (free_cnt_q == FCW'(FREE_W - 1)) begin
                    state_d    = DRAIN;
                    free_cnt_d = '0;
                end else begin
                    free_cnt_d = free_cnt_q + 1'b1;
                end
            end
            DRAIN: if (!req_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            free_cnt_q <= '0;
            free_q     <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            free_cnt_q <= free_cnt_d;
            free_q     <= (state_d == FREE);
            clr_q      <= (state_d == FREE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= hold_q;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign o_free  = free_q;
    assign o_valid = valid_q;
    assign o_count = count_q;
    assign o_data  = mem[rd_ptr];
endmodule
